// File: rtl/booth_mult_seq_pkg.sv
// Shared types and constants for the sequential radix-4 Booth multiplier.
// Holds the controller state encoding and the default operand width.
package booth_mult_seq_pkg;

    localparam int unsigned DefaultN = 32;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

endpackage

// File: rtl/booth_selector.sv
// Radix-4 Booth partial-product selector: picks 0, Y or 2Y at N+1 bits and
// one's-complements it for negative digits (the +1 is added by the caller).
module booth_selector #(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0] y,
    input  logic         one,
    input  logic         two,
    input  logic         neg,
    output logic [N:0]   pp
);

    logic [N:0] sel;

    always_comb begin
        sel = '0;
        if (one) begin
            sel = {y[N-1], y};
        end else if (two) begin
            sel = {y, 1'b0};
        end
        pp = sel ^ {(N + 1){neg}};
    end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential signed N x N multiplier retiring one radix-4 Booth digit per clock.
// Result is published on product only when the last digit has been accumulated.
module booth_mult_seq
    import booth_mult_seq_pkg::*;
#(
    parameter int unsigned N = DefaultN
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   multiplicand,
    input  logic [N-1:0]   multiplier,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int unsigned CntW = $clog2(N / 2);
    localparam logic [CntW-1:0] CntLast = CntW'(N / 2 - 1);

    state_e           state_q, state_d;
    logic [N-1:0]     y_q, y_d;
    logic [N-1:0]     x_q, x_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [2*N-1:0]   acc_q, acc_d;
    logic [2*N-1:0]   product_q, product_d;

    logic [N:0]       x_ext;
    logic [CntW:0]    shamt;
    logic [2:0]       dig;
    logic             one, two, neg;
    logic [N:0]       pp;
    logic [2*N-1:0]   pp_ext;
    logic [2*N-1:0]   addend;
    logic [2*N-1:0]   acc_sum;

    // Digit i is {x[2i+1], x[2i], x[2i-1]} with an implicit zero below bit 0.
    always_comb begin
        x_ext = {x_q, 1'b0};
        shamt = {cnt_q, 1'b0};
        dig   = x_ext[shamt +: 3];
        one   = dig[1] ^ dig[0];
        two   = (dig[2] & ~dig[1] & ~dig[0]) | (~dig[2] & dig[1] & dig[0]);
        neg   = dig[2];
    end

    booth_selector #(
        .N (N)
    ) u_booth_selector (
        .y   (y_q),
        .one (one),
        .two (two),
        .neg (neg),
        .pp  (pp)
    );

    // The neg term completes the two's complement of the inverted selection.
    always_comb begin
        pp_ext  = {{(N - 1){pp[N]}}, pp};
        addend  = (pp_ext << shamt) + ({{(2 * N - 1){1'b0}}, neg} << shamt);
        acc_sum = acc_q + addend;
    end

    always_comb begin
        state_d   = state_q;
        y_d       = y_q;
        x_d       = x_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        product_d = product_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    y_d     = multiplicand;
                    x_d     = multiplier;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                acc_d = acc_sum;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntLast) begin
                    product_d = acc_sum;
                    cnt_d     = '0;
                    state_d   = StDone;
                end
            end
            StDone: begin
                if (start) begin
                    y_d     = multiplicand;
                    x_d     = multiplier;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = StRun;
                end else begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            y_q       <= '0;
            x_q       <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            y_q       <= y_d;
            x_q       <= x_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            product_q <= product_d;
        end
    end

    assign busy    = (state_q == StRun);
    assign done    = (state_q == StDone);
    assign product = product_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed bench for booth_mult_seq at N=32: latency, products, ignored
// starts, back-to-back operation and asynchronous reset mid-run.
module tb_booth_mult_seq;

    localparam int unsigned N = 32;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [N-1:0]   multiplicand;
    logic [N-1:0]   multiplier;
    logic           busy;
    logic           done;
    logic [2*N-1:0] product;

    int n_checks = 0;
    int n_fail   = 0;

    booth_mult_seq #(
        .N (N)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full multiply from IDLE/DONE: checks busy length, done timing, pulse width.
    task automatic run_mult(input string tag, input logic [N-1:0] y, input logic [N-1:0] x,
                            input logic [2*N-1:0] exp);
        int edges;
        int busy_cnt;
        start        = 1'b1;
        multiplicand = y;
        multiplier   = x;
        tick();
        start        = 1'b0;
        multiplicand = '1;
        multiplier   = '1;
        busy_cnt     = busy ? 1 : 0;
        edges        = 0;
        do begin
            tick();
            edges++;
            if (busy) busy_cnt++;
        end while (!done && edges < 40);
        check({tag, "_latency"}, 64'(edges), 64'd16);
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd16);
        check({tag, "_product"}, product, exp);
        tick();
        check({tag, "_done_pulse"}, {62'd0, busy, done}, 64'd0);
        check({tag, "_held"}, product, exp);
    endtask

    initial begin
        int e;
        rst_n        = 1'b0;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        #12;
        check("reset_outputs", {busy, done, product}, 66'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        run_mult("y5_x3", 32'd5, 32'd3, 64'd15);
        run_mult("neg1_sq", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1);
        run_mult("min_sq", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        run_mult("max_min", 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000);

        // Start during RUN must be ignored and product must hold the old result.
        start        = 1'b1;
        multiplicand = 32'd7;
        multiplier   = 32'd6;
        tick();
        start = 1'b0;
        e     = 0;
        repeat (4) begin
            tick();
            e++;
        end
        start        = 1'b1;
        multiplicand = 32'd9;
        multiplier   = 32'd9;
        tick();
        e++;
        start = 1'b0;
        check("ign_busy", 64'(busy), 64'd1);
        check("ign_prod_stable", product, 64'hC000_0000_8000_0000);
        do begin
            tick();
            e++;
        end while (!done && e < 40);
        check("ign_latency", 64'(e), 64'd16);
        check("ign_product", product, 64'd42);
        tick();

        run_mult("zero_y", 32'd0, 32'h1234_5678, 64'd0);

        // Back-to-back with start held high; new operands presented in DONE.
        start        = 1'b1;
        multiplicand = 32'd3;
        multiplier   = 32'd4;
        tick();
        check("b2b_accept0", 64'(busy), 64'd1);
        for (int k = 0; k < 3; k++) begin
            e = 0;
            do begin
                tick();
                e++;
            end while (!done && e < 40);
            check($sformatf("b2b_latency%0d", k), 64'(e), 64'd16);
            case (k)
                0: begin
                    check("b2b_prod0", product, 64'd12);
                    multiplicand = 32'hFFFF_FFFB;
                    multiplier   = 32'd6;
                end
                1: begin
                    check("b2b_prod1", product, 64'hFFFF_FFFF_FFFF_FFE2);
                    multiplicand = 32'h7FFF_FFFF;
                    multiplier   = 32'h7FFF_FFFF;
                end
                default: begin
                    check("b2b_prod2", product, 64'h3FFF_FFFF_0000_0001);
                    start = 1'b0;
                end
            endcase
            tick();
            check($sformatf("b2b_after%0d", k), {62'd0, busy, done},
                  (k < 2) ? 64'd2 : 64'd0);
        end

        // Asynchronous reset at RUN cycle 8.
        start        = 1'b1;
        multiplicand = 32'd100;
        multiplier   = 32'd100;
        tick();
        start = 1'b0;
        repeat (7) tick();
        check("rst_pre_busy", 64'(busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async", {busy, done, product}, 66'd0);
        tick();
        check("rst_hold", {busy, done, product}, 66'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_mult("after_rst", 32'd2, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFA);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
